// File: rtl/sp_lsu_mem_initiator.sv
// rtl/sp_lsu_mem_initiator.sv - byte/half/word load-store initiator for a 32-bit word memory
//
// Ports:
//   clk_i, arst_ni              clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   request handshake (req_we_i, req_size_i, req_signed_i,
//                               req_addr_i, req_wdata_i)
//   rsp_valid_o / rsp_ready_i   response handshake (rsp_rdata_o, rsp_err_o)
//   mem_r_addr_o, mem_r_data_i  word-aligned read port, data combinational on address
//   mem_we_o, mem_w_addr_o,     word-aligned write port, committed on the clock edge
//   mem_w_data_o                that ends the WRITE state
module sp_lsu_mem_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] mem_r_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_r_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_w_addr_o,
  output logic [DATA_WIDTH-1:0] mem_w_data_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t state_q, state_d;

  logic                  we_q;
  logic [1:0]            size_q;
  logic                  sgn_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  err_q;

  logic                  err_c;
  logic [7:0]            byte_c;
  logic [15:0]           half_c;
  logic [DATA_WIDTH-1:0] load_c;
  logic [DATA_WIDTH-1:0] merge_c;

  // Alignment/size check on the latched request.
  always_comb begin
    err_c = (size_q == 2'd3)
          | ((size_q == 2'd1) & off_q[0])
          | ((size_q == 2'd2) & (off_q != 2'b00));
  end

  // Little-endian lane extraction and sign/zero extension for loads.
  always_comb begin
    byte_c = mem_r_data_i[{off_q, 3'b000} +: 8];
    half_c = off_q[1] ? mem_r_data_i[31:16] : mem_r_data_i[15:0];
    case (size_q)
      2'd0:    load_c = {{24{sgn_q & byte_c[7]}}, byte_c};
      2'd1:    load_c = {{16{sgn_q & half_c[15]}}, half_c};
      default: load_c = mem_r_data_i;
    endcase
  end

  // Read-modify-write merge: the memory only writes whole words, so sub-word
  // stores splice the new lane(s) into the word read during ACCESS.
  always_comb begin
    merge_c = mem_r_data_i;
    case (size_q)
      2'd0: merge_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      2'd1: begin
        if (off_q[1]) merge_c[31:16] = wdata_q[15:0];
        else          merge_c[15:0]  = wdata_q[15:0];
      end
      default: merge_c = wdata_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = ACCESS;
      ACCESS:  state_d = (err_c || !we_q) ? RESP : WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sgn_q       <= 1'b0;
      off_q       <= 2'b00;
      wdata_q     <= '0;
      addr_q      <= '0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            sgn_q   <= req_signed_i;
            off_q   <= req_addr_i[1:0];
            wdata_q <= req_wdata_i;
            addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
          end
        end
        ACCESS: begin
          if (err_c) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (!we_q) begin
            rdata_q <= load_c;
            err_q   <= 1'b0;
          end else begin
            mem_wdata_q <= merge_c;
            rdata_q     <= '0;
            err_q       <= 1'b0;
          end
        end
        RESP: begin
          if (rsp_ready_i) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Handshake and write-enable are pure state decodes, so an asynchronous
  // reset during WRITE removes mem_we_o before the committing edge.
  assign req_ready_o  = (state_q == IDLE);
  assign mem_we_o     = (state_q == WRITE);
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign mem_r_addr_o = addr_q;
  assign mem_w_addr_o = addr_q;
  assign mem_w_data_o = mem_wdata_q;

endmodule

// File: tb/tb_sp_lsu_mem_initiator.sv
// tb/tb_sp_lsu_mem_initiator.sv - self-checking bench for sp_lsu_mem_initiator
module tb_sp_lsu_mem_initiator;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [31:0] mem_r_addr_o;
  logic [31:0] mem_r_data_i;
  logic        mem_we_o;
  logic [31:0] mem_w_addr_o;
  logic [31:0] mem_w_data_o;

  int n_pass = 0;
  int n_total = 0;

  // Word memory seen by the DUT and a byte-level reference memory.
  bit [31:0] mem  [0:255];
  bit [7:0]  rmem [0:1023];

  always #5 clk_i = ~clk_i;

  assign mem_r_data_i = mem[mem_r_addr_o[9:2]];
  always @(posedge clk_i) if (mem_we_o) mem[mem_w_addr_o[9:2]] <= mem_w_data_o;

  sp_lsu_mem_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .arst_ni(arst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_signed_i(req_signed_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .mem_r_addr_o(mem_r_addr_o),
    .mem_r_data_i(mem_r_data_i), .mem_we_o(mem_we_o), .mem_w_addr_o(mem_w_addr_o),
    .mem_w_data_o(mem_w_data_o)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_rdata, logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
  endfunction

  // Byte-addressed reference: errors never touch memory, stores write n bytes,
  // loads gather n bytes and extend from the top bit.
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err);
    int n;
    int a;
    logic [31:0] v;
    a   = int'(addr[9:0]);
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    rd  = 32'h0;
    if (!err) begin
      n = 1 << size;
      if (we) begin
        for (int i = 0; i < n; i++) rmem[a+i] = 8'(wdata >> (8*i));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(rmem[a+i]) << (8*i));
        if (sgn && v[8*n-1]) for (int i = n; i < 4; i++) v = v | (32'hFF << (8*i));
        rd = v;
      end
    end
  endtask

  // Starts and ends just after a falling edge. Latencies count falling edges
  // after the accepting rising edge; -1 means never seen within the budget.
  task automatic transact(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err,
                          output int rsp_lat, output int we_lat);
    req_we_i = we; req_size_i = size; req_signed_i = sgn;
    req_addr_i = addr; req_wdata_i = wdata; req_valid_i = 1'b1;
    rsp_lat = -1; we_lat = -1; rd = 32'hx; err = 1'bx;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we_o && we_lat < 0) we_lat = c;
      if (rsp_valid_o) begin
        rsp_lat = c; rd = rsp_rdata_o; err = rsp_err_o;
        break;
      end
      @(negedge clk_i);
    end
    @(negedge clk_i);
  endtask

  task automatic run_one(input string tag, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic err;
    int rl, wl;
    logic ok;
    transact(we, size, sgn, addr, wdata, rd, err, rl, wl);
    ok = we && !exp_err;
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_rsp_lat"}, rl, ok ? 3 : 2);
    check({tag, "_we_lat"}, wl, ok ? 2 : -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] mrd, r0, old;
    logic merr;
    int bad;

    arst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_size_i = 2'd0;
    req_signed_i = 1'b0; req_addr_i = 32'h0; req_wdata_i = 32'h0; rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_r_addr", mem_r_addr_o, 32'h0);
    check("rst_w_addr", mem_w_addr_o, 32'h0);
    check("rst_err", 32'(rsp_err_o), 32'd0);
    arst_ni = 1'b1;
    @(negedge clk_i);

    // we, size, sgn, addr, wdata, expected rdata, expected err
    vt.push_back(mk(1, 2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0));
    vt.push_back(mk(0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0));
    vt.push_back(mk(0, 0, 0, 32'h100, 32'h0, 32'h000000EF, 0));
    vt.push_back(mk(0, 0, 1, 32'h103, 32'h0, 32'hFFFFFFDE, 0));
    vt.push_back(mk(1, 2, 0, 32'h100, 32'h11223344, 32'h0, 0));
    vt.push_back(mk(1, 0, 0, 32'h102, 32'hFFFFFFAA, 32'h0, 0));
    vt.push_back(mk(0, 2, 0, 32'h100, 32'h0, 32'h11AA3344, 0));
    vt.push_back(mk(1, 2, 0, 32'h200, 32'h80FF7F01, 32'h0, 0));
    vt.push_back(mk(0, 0, 1, 32'h201, 32'h0, 32'h0000007F, 0));
    vt.push_back(mk(0, 0, 1, 32'h202, 32'h0, 32'hFFFFFFFF, 0));
    vt.push_back(mk(0, 1, 0, 32'h202, 32'h0, 32'h000080FF, 0));
    vt.push_back(mk(0, 1, 1, 32'h202, 32'h0, 32'hFFFF80FF, 0));
    vt.push_back(mk(1, 1, 0, 32'h101, 32'h12345678, 32'h0, 1));
    vt.push_back(mk(0, 2, 0, 32'h102, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 3, 0, 32'h104, 32'h0, 32'h0, 1));
    vt.push_back(mk(0, 2, 0, 32'h100, 32'h0, 32'h11AA3344, 0));
    vt.push_back(mk(1, 1, 0, 32'h202, 32'h1234ABCD, 32'h0, 0));
    vt.push_back(mk(0, 2, 0, 32'h200, 32'h0, 32'hABCD7F01, 0));

    foreach (vt[i]) begin
      model(vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr, vt[i].wdata, mrd, merr);
      run_one($sformatf("vec%0d", i), vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr,
              vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);
    end
    check("mem_0x100", mem[32'h100 >> 2], 32'h11AA3344);
    check("mem_0x200", mem[32'h200 >> 2], 32'hABCD7F01);

    // Backpressure: response must hold still while rsp_ready_i is low.
    rsp_ready_i = 1'b0;
    req_we_i = 1'b0; req_size_i = 2'd2; req_signed_i = 1'b0;
    req_addr_i = 32'h200; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("bp_valid", 32'(rsp_valid_o), 32'd1);
    r0 = rsp_rdata_o;
    check("bp_rdata", r0, ref_word(32'h200));
    bad = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (!rsp_valid_o || rsp_rdata_o !== r0 || req_ready_o || rsp_err_o) bad++;
    end
    check("bp_stable_cycles", bad, 0);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_valid", 32'(rsp_valid_o), 32'd0);
    check("bp_release_ready", 32'(req_ready_o), 32'd1);

    // Reset while in WRITE: the write must not land, and the block recovers.
    old = ref_word(32'h300);
    req_we_i = 1'b1; req_size_i = 2'd2; req_addr_i = 32'h300;
    req_wdata_i = 32'h55AA55AA; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("wr_rst_we_before", 32'(mem_we_o), 32'd1);
    #1 arst_ni = 1'b0;
    #1;
    check("wr_rst_we_drop", 32'(mem_we_o), 32'd0);
    check("wr_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("wr_rst_req_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    arst_ni = 1'b1;
    check("wr_rst_mem_kept", mem[32'h300 >> 2], old);
    run_one("post_rst_load", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, old, 1'b0);

    // Randomized requests against the byte-level reference.
    for (int i = 0; i < 300; i++) begin
      logic        we, sgn;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      we    = 1'($urandom_range(0, 1));
      sgn   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd2) addr[1:0] = 2'b00;
        if (size == 2'd1) addr[0] = 1'b0;
      end
      wdata = $urandom;
      model(we, size, sgn, addr, wdata, mrd, merr);
      run_one($sformatf("rnd%0d", i), we, size, sgn, addr, wdata, mrd, merr);
    end

    bad = 0;
    for (int w = 0; w < 256; w++) if (mem[w] !== ref_word(w * 4)) bad++;
    check("mem_sweep_bad_words", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
